// File: rtl/write_path_scheduler.sv
// Shared AXI write-path scheduler: round-robin AW grant between two masters,
// path locked to the winner through address, data beats and write response.
module write_path_scheduler #(
    parameter int LEN_WIDTH = 8
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 M0_awvalid,
    input  logic                 M1_awvalid,
    input  logic [LEN_WIDTH-1:0] M0_awlen,
    input  logic [LEN_WIDTH-1:0] M1_awlen,
    output logic                 M0_awready,
    output logic                 M1_awready,
    output logic                 S_awvalid,
    input  logic                 S_awready,
    input  logic                 M0_wvalid,
    input  logic                 M1_wvalid,
    input  logic                 M0_wlast,
    input  logic                 M1_wlast,
    output logic                 M0_wready,
    output logic                 M1_wready,
    output logic                 S_wvalid,
    input  logic                 S_wready,
    input  logic                 S_bvalid,
    output logic                 S_bready,
    output logic                 M0_bvalid,
    output logic                 M1_bvalid,
    input  logic                 M0_bready,
    input  logic                 M1_bready,
    output logic                 Sel,
    output logic                 Busy,
    output logic                 Len_Error
);

    // state | meaning
    // IDLE  | no transaction; arbitrate AW requests
    // ADDR  | winner's AW routed to slave
    // DATA  | winner's W beats routed, beats counted down
    // RESP  | slave B routed back to winner
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    state_t               state_q, state_d;
    logic                 last_served_q;
    logic [LEN_WIDTH-1:0] cnt_q;

    logic                 any_req, grant_m1;
    logic                 sel_awvalid, sel_wvalid, sel_wlast, sel_bready;
    logic [LEN_WIDTH-1:0] sel_awlen;
    logic                 aw_hs, w_hs, b_hs;

    assign any_req  = M0_awvalid | M1_awvalid;
    // On contention the master that was not served last takes the grant.
    assign grant_m1 = M1_awvalid & (~M0_awvalid | ~last_served_q);

    assign sel_awvalid = Sel ? M1_awvalid : M0_awvalid;
    assign sel_awlen   = Sel ? M1_awlen   : M0_awlen;
    assign sel_wvalid  = Sel ? M1_wvalid  : M0_wvalid;
    assign sel_wlast   = Sel ? M1_wlast   : M0_wlast;
    assign sel_bready  = Sel ? M1_bready  : M0_bready;

    assign aw_hs = (state_q == ADDR) & sel_awvalid & S_awready;
    assign w_hs  = (state_q == DATA) & sel_wvalid  & S_wready;
    assign b_hs  = (state_q == RESP) & S_bvalid    & sel_bready;

    assign Busy = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        M0_awready = 1'b0;
        M1_awready = 1'b0;
        S_awvalid  = 1'b0;
        M0_wready  = 1'b0;
        M1_wready  = 1'b0;
        S_wvalid   = 1'b0;
        S_bready   = 1'b0;
        M0_bvalid  = 1'b0;
        M1_bvalid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) state_d = ADDR;
            end
            ADDR: begin
                S_awvalid = sel_awvalid;
                if (Sel) M1_awready = S_awready;
                else     M0_awready = S_awready;
                if (aw_hs) state_d = DATA;
            end
            DATA: begin
                S_wvalid = sel_wvalid;
                if (Sel) M1_wready = S_wready;
                else     M0_wready = S_wready;
                if (w_hs && (cnt_q == '0)) state_d = RESP;
            end
            RESP: begin
                S_bready = sel_bready;
                if (Sel) M1_bvalid = S_bvalid;
                else     M0_bvalid = S_bvalid;
                if (b_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q       <= IDLE;
            Sel           <= 1'b0;
            last_served_q <= 1'b1;
            cnt_q         <= '0;
            Len_Error     <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && any_req) Sel <= grant_m1;
            if (aw_hs) begin
                cnt_q         <= sel_awlen;
                last_served_q <= Sel;
            end
            if (w_hs) begin
                // The final beat leaves the counter at zero; it never wraps.
                if (cnt_q != '0) cnt_q <= cnt_q - LEN_ONE;
                if (sel_wlast != (cnt_q == '0)) Len_Error <= 1'b1;
            end
        end
    end

endmodule
